// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: DEC/stall-unit/memory inputs to the controller and its
// per-stage hold/flush controls, tracked destinations and perf counters.
interface pipe_hazard_ctrl_if;
  logic        dec_valid;
  logic [4:0]  dec_rd;
  logic        dec_rd_wenb, dec_load, dec_csr;
  logic        dec_stall, dec_load_use, dec_csr_use;
  logic        exe_branch_taken, mem_req, mem_ack;
  logic        fet_hold, dec_hold, dec_flush, exe_hold, mem_hold;
  logic [4:0]  exe_rd, mem_rd, wrb_rd;
  logic        exe_rd_wenb, mem_rd_wenb, wrb_rd_wenb, exe_load, exe_csr;
  logic        stall_timeout;
  logic [31:0] perf_load_use, perf_csr_use, perf_mem_wait, perf_flush;

  modport master (
    output dec_valid, dec_rd, dec_rd_wenb, dec_load, dec_csr,
           dec_stall, dec_load_use, dec_csr_use, exe_branch_taken, mem_req, mem_ack,
    input  fet_hold, dec_hold, dec_flush, exe_hold, mem_hold,
           exe_rd, mem_rd, wrb_rd, exe_rd_wenb, mem_rd_wenb, wrb_rd_wenb, exe_load, exe_csr,
           stall_timeout, perf_load_use, perf_csr_use, perf_mem_wait, perf_flush
  );
  modport slave (
    input  dec_valid, dec_rd, dec_rd_wenb, dec_load, dec_csr,
           dec_stall, dec_load_use, dec_csr_use, exe_branch_taken, mem_req, mem_ack,
    output fet_hold, dec_hold, dec_flush, exe_hold, mem_hold,
           exe_rd, mem_rd, wrb_rd, exe_rd_wenb, mem_rd_wenb, wrb_rd_wenb, exe_load, exe_csr,
           stall_timeout, perf_load_use, perf_csr_use, perf_mem_wait, perf_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencing: EXE/MEM/WRB destination tracking, hold/flush control,
// DEC-stall watchdog. Define PIPE_PERF_CNT_EN to build the 32-bit perf counters.
module pipe_hazard_ctrl #(
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, MWAIT, FLUSH} state_t;
  typedef enum logic [1:0] {ACT_ADV, ACT_STALL, ACT_SQUASH, ACT_FREEZE} act_t;
  typedef struct packed {
    logic [4:0] rd;
    logic       wenb;
    logic       load;
    logic       csr;
  } trk_t;

  state_t           state, state_nxt;
  act_t             act;
  logic             mem_wait, br_accept;
  trk_t             exe_q, exe_nxt;
  logic [4:0]       mem_rd_q, wrb_rd_q;
  logic             mem_wenb_q, wrb_wenb_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_q;

  assign mem_wait = bus.mem_req & ~bus.mem_ack;

  // One action per cycle; mem_wait overrides everything, FLUSH ignores stall and branch.
  always_comb begin
    state_nxt = RUN;
    act       = ACT_ADV;
    br_accept = 1'b0;
    if (mem_wait) begin
      act       = ACT_FREEZE;
      state_nxt = MWAIT;
    end else if (state == FLUSH) begin
      act = ACT_SQUASH;
    end else if (bus.exe_branch_taken) begin
      act       = ACT_SQUASH;
      br_accept = 1'b1;
      state_nxt = FLUSH;
    end else if (bus.dec_stall) begin
      act = ACT_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  assign bus.fet_hold  = (act == ACT_FREEZE) || (act == ACT_STALL);
  assign bus.dec_hold  = (act == ACT_FREEZE) || (act == ACT_STALL);
  assign bus.exe_hold  = (act == ACT_FREEZE);
  assign bus.mem_hold  = (act == ACT_FREEZE);
  assign bus.dec_flush = (act == ACT_SQUASH);

  // Anything other than a valid advance puts a bubble (all zero, rd included) into EXE.
  always_comb begin
    exe_nxt = '0;
    if (act == ACT_ADV && bus.dec_valid)
      exe_nxt = '{rd: bus.dec_rd, wenb: bus.dec_rd_wenb, load: bus.dec_load, csr: bus.dec_csr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q      <= '0;
      mem_rd_q   <= '0;
      mem_wenb_q <= 1'b0;
      wrb_rd_q   <= '0;
      wrb_wenb_q <= 1'b0;
    end else if (act == ACT_FREEZE) begin
      wrb_wenb_q <= 1'b0;
    end else begin
      exe_q      <= exe_nxt;
      mem_rd_q   <= exe_q.rd;
      mem_wenb_q <= exe_q.wenb;
      wrb_rd_q   <= mem_rd_q;
      wrb_wenb_q <= mem_wenb_q;
    end
  end

  assign bus.exe_rd      = exe_q.rd;
  assign bus.exe_rd_wenb = exe_q.wenb;
  assign bus.exe_load    = exe_q.load;
  assign bus.exe_csr     = exe_q.csr;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_rd_wenb = mem_wenb_q;
  assign bus.wrb_rd      = wrb_rd_q;
  assign bus.wrb_rd_wenb = wrb_wenb_q;

  // Only stalls that actually freeze FET/DEC count toward the watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else if (act == ACT_STALL) begin
      if (stall_cnt != CNT_W'(STALL_LIMIT))     stall_cnt <= stall_cnt + CNT_W'(1);
      if (stall_cnt == CNT_W'(STALL_LIMIT - 1)) timeout_q <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  assign bus.stall_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cnt_lu, cnt_cu, cnt_mw, cnt_fl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lu <= '0;
      cnt_cu <= '0;
      cnt_mw <= '0;
      cnt_fl <= '0;
    end else begin
      if (act == ACT_STALL && bus.dec_load_use) cnt_lu <= cnt_lu + 32'd1;
      if (act == ACT_STALL && bus.dec_csr_use)  cnt_cu <= cnt_cu + 32'd1;
      if (mem_wait)                             cnt_mw <= cnt_mw + 32'd1;
      if (br_accept)                            cnt_fl <= cnt_fl + 32'd1;
    end
  end

  assign bus.perf_load_use = cnt_lu;
  assign bus.perf_csr_use  = cnt_cu;
  assign bus.perf_mem_wait = cnt_mw;
  assign bus.perf_flush    = cnt_fl;
`else
  logic unused_perf;
  assign unused_perf       = ^{bus.dec_load_use, bus.dec_csr_use, br_accept};
  assign bus.perf_load_use = '0;
  assign bus.perf_csr_use  = '0;
  assign bus.perf_mem_wait = '0;
  assign bus.perf_flush    = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table with a tracking scoreboard, plus
// watchdog and reset-mid-FLUSH/MWAIT sequences.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus();
  pipe_hazard_ctrl #(.STALL_LIMIT(16), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       we, ld, cs, st, lu, cu, br, mreq, mack;
    logic [4:0] hold;   // {fet, dec, exe, mem, flush}
    logic [4:0] e_rd;
    logic       e_we, e_ld, e_cs;
    logic [4:0] m_rd;
    logic       m_we;
    logic [4:0] w_rd;
    logic       w_we;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int v, rd, we, ld, cs, st, lu, cu, br, mreq, mack,
                              input int hold, erd, ewe, eld, ecs, mrd, mwe, wrd, wwe);
    vec_t t;
    t.v = 1'(v);   t.rd = 5'(rd);  t.we = 1'(we);  t.ld = 1'(ld);  t.cs = 1'(cs);
    t.st = 1'(st); t.lu = 1'(lu);  t.cu = 1'(cu);  t.br = 1'(br);
    t.mreq = 1'(mreq); t.mack = 1'(mack);
    t.hold = 5'(hold);
    t.e_rd = 5'(erd); t.e_we = 1'(ewe); t.e_ld = 1'(eld); t.e_cs = 1'(ecs);
    t.m_rd = 5'(mrd); t.m_we = 1'(mwe); t.w_rd = 5'(wrd); t.w_we = 1'(wwe);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_in(input vec_t t);
    bus.dec_valid = t.v;  bus.dec_rd = t.rd; bus.dec_rd_wenb = t.we;
    bus.dec_load = t.ld;  bus.dec_csr = t.cs;
    bus.dec_stall = t.st; bus.dec_load_use = t.lu; bus.dec_csr_use = t.cu;
    bus.exe_branch_taken = t.br; bus.mem_req = t.mreq; bus.mem_ack = t.mack;
  endtask

  function automatic logic [31:0] holds();
    return 32'({bus.fet_hold, bus.dec_hold, bus.exe_hold, bus.mem_hold, bus.dec_flush});
  endfunction

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    set_in(t);
    #1;
    chk($sformatf("v%0d hold", idx), holds(), 32'(t.hold));
    exp_q.push_back(t);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      chk($sformatf("v%0d scoreboard empty", idx), 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d exe", idx),
          32'({bus.exe_rd, bus.exe_rd_wenb, bus.exe_load, bus.exe_csr}),
          32'({e.e_rd, e.e_we, e.e_ld, e.e_cs}));
      chk($sformatf("v%0d mem", idx), 32'({bus.mem_rd, bus.mem_rd_wenb}), 32'({e.m_rd, e.m_we}));
      chk($sformatf("v%0d wrb", idx), 32'({bus.wrb_rd, bus.wrb_rd_wenb}), 32'({e.w_rd, e.w_we}));
    end
  endtask

  task automatic cyc(input vec_t t);
    set_in(t);
    @(posedge clk); #1;
  endtask

  task automatic chk_tracking_zero(input string nm);
    chk({nm, " trk"}, 32'({bus.exe_rd, bus.exe_rd_wenb, bus.exe_load, bus.exe_csr,
                           bus.mem_rd, bus.mem_rd_wenb, bus.wrb_rd, bus.wrb_rd_wenb}), 32'd0);
    chk({nm, " timeout"}, 32'(bus.stall_timeout), 32'd0);
    chk({nm, " perf"}, bus.perf_load_use | bus.perf_csr_use | bus.perf_mem_wait | bus.perf_flush, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t z;
    int   lu_exp, cu_exp, mw_exp, fl_exp;
    z = mk(0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0, 0,0, 0,0);
    set_in(z);
    repeat (2) @(posedge clk);
    #1;
    chk("reset hold", holds(), 32'd0);
    chk_tracking_zero("reset");
    rst_n = 1'b1;

    //             v rd we ld cs st lu cu br mq ma  hold      erd ewe eld ecs mrd mwe wrd wwe
    tbl.push_back(mk(1, 5,1,0,0,0,0,0,0,0,0, 5'b00000,  5,1,0,0,  0,0,  0,0));
    tbl.push_back(mk(1, 5,1,0,0,0,0,0,0,0,0, 5'b00000,  5,1,0,0,  5,1,  0,0));
    tbl.push_back(mk(1, 5,1,0,0,0,0,0,0,0,0, 5'b00000,  5,1,0,0,  5,1,  5,1));
    tbl.push_back(mk(1, 7,1,1,0,0,0,0,0,0,0, 5'b00000,  7,1,1,0,  5,1,  5,1));
    tbl.push_back(mk(1, 8,1,0,0,1,1,0,0,0,0, 5'b11000,  0,0,0,0,  7,1,  5,1));
    tbl.push_back(mk(1, 8,1,0,0,0,0,0,0,0,0, 5'b00000,  8,1,0,0,  0,0,  7,1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 9,0,0,1,0,0,0,0,1,0, 5'b11110, 8,1,0,0,  0,0,  7,0));
    tbl.push_back(mk(1, 9,0,0,1,0,0,0,0,1,1, 5'b00000,  9,0,0,1,  8,1,  0,0));
    tbl.push_back(mk(1,12,1,0,0,1,1,0,1,0,0, 5'b00001,  0,0,0,0,  9,0,  8,1));
    tbl.push_back(mk(1,12,1,0,0,1,1,1,1,0,0, 5'b00001,  0,0,0,0,  0,0,  9,0));
    tbl.push_back(mk(1,13,1,0,0,0,0,0,0,0,0, 5'b00000, 13,1,0,0,  0,0,  0,0));
    tbl.push_back(mk(1,14,1,0,0,0,0,0,1,1,0, 5'b11110, 13,1,0,0,  0,0,  0,0));
    tbl.push_back(mk(1,14,1,0,0,0,0,0,1,1,1, 5'b00001,  0,0,0,0, 13,1,  0,0));
    tbl.push_back(mk(1,14,1,0,0,0,0,0,0,0,0, 5'b00001,  0,0,0,0,  0,0, 13,1));
    tbl.push_back(mk(0,15,1,0,0,0,0,0,0,0,0, 5'b00000,  0,0,0,0,  0,0,  0,0));
    tbl.push_back(mk(1,16,0,0,0,0,0,0,0,0,0, 5'b00000, 16,0,0,0,  0,0,  0,0));
    tbl.push_back(mk(1,17,1,0,0,0,0,0,0,0,0, 5'b00000, 17,1,0,0, 16,0,  0,0));
    tbl.push_back(mk(1, 0,0,0,0,0,0,0,0,0,0, 5'b00000,  0,0,0,0, 17,1, 16,0));
    tbl.push_back(mk(1, 3,1,0,0,1,0,1,0,0,0, 5'b11000,  0,0,0,0,  0,0, 17,1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

`ifdef PIPE_PERF_CNT_EN
    lu_exp = 1; cu_exp = 1; mw_exp = 5; fl_exp = 2;
`else
    lu_exp = 0; cu_exp = 0; mw_exp = 0; fl_exp = 0;
`endif
    chk("perf_load_use", bus.perf_load_use, 32'(lu_exp));
    chk("perf_csr_use",  bus.perf_csr_use,  32'(cu_exp));
    chk("perf_mem_wait", bus.perf_mem_wait, 32'(mw_exp));
    chk("perf_flush",    bus.perf_flush,    32'(fl_exp));
    chk("timeout idle",  32'(bus.stall_timeout), 32'd0);

    // Watchdog: 16 consecutive stalls set the sticky flag on the 16th edge.
    z = mk(0,0,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0, 0,0, 0,0);
    cyc(z);
    z.st = 1'b1;
    for (int i = 0; i < 15; i++) cyc(z);
    chk("wd fet_hold", 32'(bus.fet_hold), 32'd1);
    chk("wd after 15", 32'(bus.stall_timeout), 32'd0);
    cyc(z);
    chk("wd after 16", 32'(bus.stall_timeout), 32'd1);
    z.st = 1'b0;
    cyc(z);
    cyc(z);
    chk("wd sticky", 32'(bus.stall_timeout), 32'd1);

    // Reset while in FLUSH: back to RUN, so the stall is honoured again.
    z = mk(1,6,1,0,0,0,0,0,0,0,0, 0, 0,0,0,0, 0,0, 0,0);
    cyc(z);
    z.br = 1'b1;
    cyc(z);
    chk("flush mem_rd", 32'({bus.mem_rd, bus.mem_rd_wenb}), 32'({5'd6, 1'b1}));
    z.br = 1'b0; z.st = 1'b1; z.lu = 1'b1;
    set_in(z);
    #1;
    chk("flush 2nd cycle hold", holds(), 32'b00001);
    rst_n = 1'b0;
    #1;
    chk_tracking_zero("rst in flush");
    chk("rst in flush hold", holds(), 32'b11000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while in MWAIT.
    z = mk(0,0,0,0,0,0,0,0,0,1,0, 0, 0,0,0,0, 0,0, 0,0);
    cyc(z);
    cyc(z);
    chk("mwait hold", holds(), 32'b11110);
    rst_n = 1'b0;
    #1;
    chk_tracking_zero("rst in mwait");
    rst_n = 1'b1;
    z = mk(1,4,1,0,0,0,0,0,0,0,0, 0, 0,0,0,0, 0,0, 0,0);
    set_in(z);
    #1;
    chk("post-rst hold", holds(), 32'd0);
    @(posedge clk); #1;
    chk("post-rst exe", 32'({bus.exe_rd, bus.exe_rd_wenb}), 32'({5'd4, 1'b1}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
